// File: rtl/stage_writeback_if.sv
// ----------------------------------------------------------------------------
// stage_writeback_if
//   Handshake bundle between the memory stage (master) and the writeback
//   stage (slave). The master presents one instruction at a time. A transfer
//   happens in a cycle where in_valid & in_ready are both high.
//
//   in_valid        master -> slave  instruction present
//   in_ready        slave  -> master writeback can accept
//   in_instr        master -> slave  instruction word, 32'h0 = no-op
//   in_rd           master -> slave  destination register
//   in_wen          master -> slave  instruction writes in_rd
//   in_is_load      master -> slave  result comes from the memory response
//   in_load_size    master -> slave  00 word, 01 half, 10 byte, 11 word
//   in_load_signed  master -> slave  sign-extend sub-word loads
//   in_result       master -> slave  ALU result for non-load instructions
// ----------------------------------------------------------------------------
interface stage_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_is_load;
  logic [1:0]  in_load_size;
  logic        in_load_signed;
  logic [31:0] in_result;

  modport master (
    output in_valid, in_instr, in_rd, in_wen, in_is_load,
           in_load_size, in_load_signed, in_result,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_instr, in_rd, in_wen, in_is_load,
           in_load_size, in_load_signed, in_result,
    output in_ready
  );
endinterface

// File: rtl/stage_writeback.sv
// ----------------------------------------------------------------------------
// stage_writeback
//   Final pipeline stage and sole writer of the register file write port.
//   ALU results retire one cycle after acceptance. A load parks in WAIT_LOAD
//   until mem_rsp_valid, holding off upstream (in_ready=0) and exposing its
//   destination on busy_valid/busy_reg for hazard stalls.
//
// Ports
//   clk                  clock, all state changes on posedge
//   rst                  synchronous active-low reset (0 = reset)
//   up                   stage_writeback_if.slave, instruction handshake
//   mem_rsp_valid        load data valid, one-cycle pulse
//   mem_rsp_data         load data, addressed byte/half in the low bits
//   write_reg            register file write address (holds when not writing)
//   reg_file_write_data  register file write data (holds when not writing)
//   reg_file_write_en    register file write strobe
//   wb_ireg_out          instruction retired this cycle, 0 if none
//   busy_valid           load pending with nonzero, enabled destination
//   busy_reg             destination of pending load, 0 in IDLE
//   rsp_unexpected       sticky flag: response seen while not waiting
//
// Configuration
//   WB_BYPASS_EN  adds bypass_valid/bypass_reg/bypass_data: combinational
//                 copies of the write that will land on the next edge.
// ----------------------------------------------------------------------------
module stage_writeback (
  input  logic                clk,
  input  logic                rst,
  stage_writeback_if.slave    up,
  input  logic                mem_rsp_valid,
  input  logic [31:0]         mem_rsp_data,
  output logic [4:0]          write_reg,
  output logic [31:0]         reg_file_write_data,
  output logic                reg_file_write_en,
  output logic [31:0]         wb_ireg_out,
  output logic                busy_valid,
  output logic [4:0]          busy_reg,
  output logic                rsp_unexpected
`ifdef WB_BYPASS_EN
  ,
  output logic                bypass_valid,
  output logic [4:0]          bypass_reg,
  output logic [31:0]         bypass_data
`endif
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Fields of the load currently waiting for its response.
  logic [31:0] ld_instr;
  logic [4:0]  ld_rd;
  logic        ld_wen;
  logic [1:0]  ld_size;
  logic        ld_signed;

  // Retirement computed this cycle, registered onto the write port next edge.
  logic        ret_fire;
  logic        ret_wr;
  logic [4:0]  ret_rd;
  logic [31:0] ret_data;
  logic [31:0] ret_instr;
  logic        capture_load;
  logic        flag_rsp;

  // Selects the addressed byte/half and extends it to 32 bits.
  function automatic logic [31:0] format_load(input logic [31:0] d,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    case (size)
      2'b01:   return {{16{sgn & d[15]}}, d[15:0]};
      2'b10:   return {{24{sgn & d[7]}},  d[7:0]};
      default: return d;
    endcase
  endfunction

  assign up.in_ready = (state == IDLE);
  assign busy_valid  = (state == WAIT_LOAD) && ld_wen && (ld_rd != 5'd0);
  assign busy_reg    = (state == WAIT_LOAD) ? ld_rd : 5'd0;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    ret_fire     = 1'b0;
    ret_wr       = 1'b0;
    ret_rd       = 5'd0;
    ret_data     = 32'd0;
    ret_instr    = 32'd0;
    capture_load = 1'b0;
    flag_rsp     = 1'b0;

    case (state)
      IDLE: begin
        // Responses are only meaningful while a load is waiting.
        flag_rsp = mem_rsp_valid;
        // A zero instruction word is a bubble regardless of its other fields.
        if (up.in_valid && (up.in_instr != 32'd0)) begin
          if (up.in_is_load) begin
            capture_load = 1'b1;
            state_nxt    = WAIT_LOAD;
          end else begin
            ret_fire  = 1'b1;
            ret_wr    = up.in_wen && (up.in_rd != 5'd0);
            ret_rd    = up.in_rd;
            ret_data  = up.in_result;
            ret_instr = up.in_instr;
          end
        end
      end
      WAIT_LOAD: begin
        // in_valid is deliberately ignored here; upstream holds its data.
        if (mem_rsp_valid) begin
          ret_fire  = 1'b1;
          ret_wr    = ld_wen && (ld_rd != 5'd0);
          ret_rd    = ld_rd;
          ret_data  = format_load(mem_rsp_data, ld_size, ld_signed);
          ret_instr = ld_instr;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= IDLE;
      // NOTE: the latched load fields are plain flops, so they are cleared
      // too; a reset discards any pending load completely.
      ld_instr            <= 32'd0;
      ld_rd               <= 5'd0;
      ld_wen              <= 1'b0;
      ld_size             <= 2'd0;
      ld_signed           <= 1'b0;
      write_reg           <= 5'd0;
      reg_file_write_data <= 32'd0;
      reg_file_write_en   <= 1'b0;
      wb_ireg_out         <= 32'd0;
      rsp_unexpected      <= 1'b0;
    end else begin
      state             <= state_nxt;
      reg_file_write_en <= ret_wr;
      wb_ireg_out       <= ret_fire ? ret_instr : 32'd0;
      if (capture_load) begin
        ld_instr  <= up.in_instr;
        ld_rd     <= up.in_rd;
        ld_wen    <= up.in_wen;
        ld_size   <= up.in_load_size;
        ld_signed <= up.in_load_signed;
      end
      // Address and data only move on an actual write.
      if (ret_wr) begin
        write_reg           <= ret_rd;
        reg_file_write_data <= ret_data;
      end
      if (flag_rsp) begin
        rsp_unexpected <= 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign bypass_valid = ret_wr;
  assign bypass_reg   = ret_rd;
  assign bypass_data  = ret_data;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// ----------------------------------------------------------------------------
// tb_stage_writeback
//   Directed scenarios for reset, ALU, loads, r0/no-op, unexpected responses
//   and back-to-back retirement, followed by a randomized instruction stream
//   checked against a transaction-level model (queue of expected
//   retirements plus the last written register/data).
// ----------------------------------------------------------------------------
module tb_stage_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  write_reg;
  logic [31:0] reg_file_write_data;
  logic        reg_file_write_en;
  logic [31:0] wb_ireg_out;
  logic        busy_valid;
  logic [4:0]  busy_reg;
  logic        rsp_unexpected;
`ifdef WB_BYPASS_EN
  logic        bypass_valid;
  logic [4:0]  bypass_reg;
  logic [31:0] bypass_data;
`endif

  stage_writeback_if bus ();

  stage_writeback dut (
    .clk                 (clk),
    .rst                 (rst),
    .up                  (bus),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_data        (mem_rsp_data),
    .write_reg           (write_reg),
    .reg_file_write_data (reg_file_write_data),
    .reg_file_write_en   (reg_file_write_en),
    .wb_ireg_out         (wb_ireg_out),
    .busy_valid          (busy_valid),
    .busy_reg            (busy_reg),
    .rsp_unexpected      (rsp_unexpected)
`ifdef WB_BYPASS_EN
    ,
    .bypass_valid        (bypass_valid),
    .bypass_reg          (bypass_reg),
    .bypass_data         (bypass_data)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } retire_t;

  retire_t     exp_q[$];
  logic [4:0]  last_reg;
  logic [31:0] last_data;
  bit          mon_en = 1'b0;

  // Load formatting by arithmetic on the numeric value.
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] size,
                                           input logic sgn);
    int unsigned v;
    v = d;
    if (size == 2'b01) begin
      v = d % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else if (size == 2'b10) begin
      v = d % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic retire_t mk_ret(input logic [31:0] instr, input logic [4:0] rd,
                                     input logic wen, input logic [31:0] data);
    retire_t r;
    r.instr = instr;
    r.en    = wen && (rd != 0);
    r.rd    = rd;
    r.data  = data;
    return r;
  endfunction

  // Retirement monitor, active during the random phase only.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_ireg_out != 32'd0 || reg_file_write_en) begin
        if (exp_q.size() == 0) begin
          check("spurious_retire", wb_ireg_out, 32'd0);
        end else begin
          retire_t r;
          r = exp_q.pop_front();
          check("rnd_instr", wb_ireg_out, r.instr);
          check("rnd_en", {31'd0, reg_file_write_en}, {31'd0, r.en});
          if (r.en) begin
            last_reg  = r.rd;
            last_data = r.data;
          end
        end
      end
      check("rnd_wreg", {27'd0, write_reg}, {27'd0, last_reg});
      check("rnd_wdata", reg_file_write_data, last_data);
    end
  end

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.in_valid       = 1'b0;
    bus.in_instr       = 32'd0;
    bus.in_rd          = 5'd0;
    bus.in_wen         = 1'b0;
    bus.in_is_load     = 1'b0;
    bus.in_load_size   = 2'd0;
    bus.in_load_signed = 1'b0;
    bus.in_result      = 32'd0;
    mem_rsp_valid      = 1'b0;
    mem_rsp_data       = 32'd0;
  endtask

  // Presents one instruction at a negedge and returns at the negedge after
  // the edge that accepted it, with in_valid dropped.
  task automatic send(input logic [31:0] instr, input logic [4:0] rd, input logic wen,
                      input logic is_load, input logic [1:0] size, input logic sgn,
                      input logic [31:0] result);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    bus.in_valid       = 1'b1;
    bus.in_instr       = instr;
    bus.in_rd          = rd;
    bus.in_wen         = wen;
    bus.in_is_load     = is_load;
    bus.in_load_size   = size;
    bus.in_load_signed = sgn;
    bus.in_result      = result;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Directed sub-word load with a 3-cycle wait.
  task automatic load_case(input string tag, input logic [1:0] size, input logic sgn,
                           input logic [31:0] data, input logic [31:0] exp);
    send(32'h0000_0203, 5'd7, 1'b1, 1'b1, size, sgn, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_wait_ready"}, {31'd0, bus.in_ready}, 32'd0);
      check({tag, "_busy_valid"}, {31'd0, busy_valid}, 32'd1);
      check({tag, "_busy_reg"}, {27'd0, busy_reg}, 32'd7);
      check({tag, "_no_write"}, {31'd0, reg_file_write_en}, 32'd0);
      @(negedge clk);
    end
    respond(data);
    check({tag, "_en"}, {31'd0, reg_file_write_en}, 32'd1);
    check({tag, "_reg"}, {27'd0, write_reg}, 32'd7);
    check({tag, "_data"}, reg_file_write_data, exp);
    check({tag, "_instr"}, wb_ireg_out, 32'h0000_0203);
    check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_busy_clr"}, {31'd0, busy_valid}, 32'd0);
  endtask

  logic [31:0] b2b_res [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();

    // 1: reset with activity on the inputs
    @(negedge clk);
    rst              = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_instr     = 32'h0000_0033;
    bus.in_rd        = 5'd3;
    bus.in_wen       = 1'b1;
    bus.in_result    = 32'h1111_1111;
    mem_rsp_valid    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_en", {31'd0, reg_file_write_en}, 32'd0);
    check("rst_wreg", {27'd0, write_reg}, 32'd0);
    check("rst_wdata", reg_file_write_data, 32'd0);
    check("rst_ireg", wb_ireg_out, 32'd0);
    check("rst_busy", {26'd0, busy_valid, busy_reg}, 32'd0);
    check("rst_unexp", {31'd0, rsp_unexpected}, 32'd0);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);

    // 2: single ALU instruction
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h1234_0001;
    bus.in_rd     = 5'd5;
    bus.in_wen    = 1'b1;
    bus.in_result = 32'hDEAD_BEEF;
`ifdef WB_BYPASS_EN
    #1;
    check("alu_byp_valid", {31'd0, bypass_valid}, 32'd1);
    check("alu_byp_reg", {27'd0, bypass_reg}, 32'd5);
    check("alu_byp_data", bypass_data, 32'hDEAD_BEEF);
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("alu_en", {31'd0, reg_file_write_en}, 32'd1);
    check("alu_reg", {27'd0, write_reg}, 32'd5);
    check("alu_data", reg_file_write_data, 32'hDEAD_BEEF);
    check("alu_instr", wb_ireg_out, 32'h1234_0001);
    @(negedge clk);
    check("alu_en_pulse", {31'd0, reg_file_write_en}, 32'd0);
    check("alu_instr_pulse", wb_ireg_out, 32'd0);
    check("alu_data_hold", reg_file_write_data, 32'hDEAD_BEEF);

    // 3: sub-word loads
    load_case("lb_s", 2'b10, 1'b1, 32'h0000_0080, 32'hFFFF_FF80);
    load_case("lb_u", 2'b10, 1'b0, 32'h0000_0080, 32'h0000_0080);
    load_case("lh_u", 2'b01, 1'b0, 32'h0000_8001, 32'h0000_8001);

    // 4: r0 ALU, r0 load, no-op
    send(32'h0000_0101, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'hCAFE_0000);
    check("r0_alu_en", {31'd0, reg_file_write_en}, 32'd0);
    check("r0_alu_instr", wb_ireg_out, 32'h0000_0101);
    check("r0_alu_hold_reg", {27'd0, write_reg}, 32'd7);
    check("r0_alu_hold_data", reg_file_write_data, 32'h0000_8001);
    send(32'h0000_0103, 5'd0, 1'b1, 1'b1, 2'd0, 1'b0, 32'd0);
    check("r0_ld_busy", {31'd0, busy_valid}, 32'd0);
    check("r0_ld_ready", {31'd0, bus.in_ready}, 32'd0);
    respond(32'h5555_5555);
    check("r0_ld_en", {31'd0, reg_file_write_en}, 32'd0);
    check("r0_ld_instr", wb_ireg_out, 32'h0000_0103);
    check("r0_ld_ready_back", {31'd0, bus.in_ready}, 32'd1);
    send(32'h0000_0000, 5'd9, 1'b1, 1'b0, 2'd0, 1'b0, 32'h7777_7777);
    check("nop_en", {31'd0, reg_file_write_en}, 32'd0);
    check("nop_instr", wb_ireg_out, 32'd0);
    check("r0_ld_unexp", {31'd0, rsp_unexpected}, 32'd0);

    // 5: unexpected response, then reset in WAIT_LOAD
    respond(32'h9999_9999);
    check("unexp_set", {31'd0, rsp_unexpected}, 32'd1);
    check("unexp_no_write", {31'd0, reg_file_write_en}, 32'd0);
    check("unexp_no_retire", wb_ireg_out, 32'd0);
    repeat (3) @(negedge clk);
    check("unexp_sticky", {31'd0, rsp_unexpected}, 32'd1);
    send(32'h0000_0303, 5'd9, 1'b1, 1'b1, 2'd0, 1'b0, 32'd0);
    check("midrst_busy_pre", {31'd0, busy_valid}, 32'd1);
    do_reset();
    check("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy_valid}, 32'd0);
    check("midrst_en", {31'd0, reg_file_write_en}, 32'd0);
    check("midrst_unexp", {31'd0, rsp_unexpected}, 32'd0);
    @(negedge clk);
    check("midrst_no_write", {31'd0, reg_file_write_en}, 32'd0);

    // 6: four back-to-back ALU instructions with in_valid held
    for (int k = 0; k < 4; k++) b2b_res[k] = $urandom;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h0000_1000 + k;
        bus.in_rd     = 5'(k + 10);
        bus.in_wen    = 1'b1;
        bus.in_is_load = 1'b0;
        bus.in_result = b2b_res[k];
`ifdef WB_BYPASS_EN
        #1;
        check("b2b_byp_data", bypass_data, b2b_res[k]);
        check("b2b_byp_reg", {27'd0, bypass_reg}, 32'(k + 10));
`endif
      end else begin
        bus.in_valid = 1'b0;
      end
      if (k > 0) begin
        check("b2b_en", {31'd0, reg_file_write_en}, 32'd1);
        check("b2b_reg", {27'd0, write_reg}, 32'(k + 9));
        check("b2b_data", reg_file_write_data, b2b_res[k-1]);
        check("b2b_instr", wb_ireg_out, 32'h0000_1000 + k - 1);
      end
      @(negedge clk);
    end
    check("b2b_end_en", {31'd0, reg_file_write_en}, 32'd0);

    // Random stream against the model
    idle_inputs();
    do_reset();
    last_reg  = 5'd0;
    last_data = 32'd0;
    exp_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      int          kind;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic        wen;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] val;
      kind  = $urandom_range(0, 9);
      instr = $urandom | 32'd1;
      rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wen   = ($urandom_range(0, 3) != 0);
      size  = 2'($urandom_range(0, 3));
      sgn   = 1'($urandom_range(0, 1));
      val   = $urandom;
      if (kind == 0) begin
        send(32'd0, rd, wen, sgn, size, sgn, val);
      end else if (kind <= 5) begin
        exp_q.push_back(mk_ret(instr, rd, wen, val));
        send(instr, rd, wen, 1'b0, size, sgn, val);
      end else begin
        int dly;
        send(instr, rd, wen, 1'b1, size, sgn, 32'd0);
        dly = $urandom_range(0, 3);
        for (int d = 0; d <= dly; d++) begin
          check("rnd_busy_valid", {31'd0, busy_valid}, {31'd0, wen && (rd != 0)});
          check("rnd_busy_reg", {27'd0, busy_reg}, {27'd0, rd});
          check("rnd_stall", {31'd0, bus.in_ready}, 32'd0);
          if (d < dly) @(negedge clk);
        end
        exp_q.push_back(mk_ret(instr, rd, wen, ref_load(val, size, sgn)));
        respond(val);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("rnd_drain", exp_q.size(), 32'd0);
    check("rnd_unexp", {31'd0, rsp_unexpected}, 32'd0);
    check("rnd_idle_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
